// File: rtl/keypad_pkg.sv
// Shared types and elaboration helpers for the matrix keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {StScan, StDebounce, StHeld} state_e;

  function automatic int unsigned code_w(input int unsigned nrows, input int unsigned ncols);
    return $clog2(nrows * ncols);
  endfunction

  function automatic bit params_ok(input int unsigned nrows, input int unsigned ncols,
                                   input int unsigned scan_div, input int unsigned deb_cnt,
                                   input int unsigned depth);
    return (nrows >= 2) && (ncols >= 2) && (scan_div >= 3) && (deb_cnt >= 1) &&
           (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/keypad_scanner_fifo.sv
// Key-event queue: circular buffer with wrap-bit pointers and a registered head output.
module key_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             overflow_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             ovf_q, ovf_d;
  logic             do_push, do_pop;

  assign empty_o    = (wptr_q == rptr_q);
  assign full_o     = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign do_pop     = pop_i && !empty_o;
  // A pop frees the slot this cycle, so a full queue still accepts a simultaneous push.
  assign do_push    = push_i && (!full_o || do_pop);
  assign dout_o     = dout_q;
  assign overflow_o = ovf_q;

  always_comb begin
    wptr_d = wptr_q + PW'(do_push);
    rptr_d = rptr_q + PW'(do_pop);
    ovf_d  = ovf_q | (push_i & ~do_push);
    dout_d = mem_q[rptr_d[AW-1:0]];
    if (do_push && (wptr_q[AW-1:0] == rptr_d[AW-1:0])) begin
      dout_d = din_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= din_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      dout_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      dout_q <= dout_d;
      ovf_q  <= ovf_d;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: column drive, row sync, debounce, auto-repeat and a key-event queue.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned NROWS        = 4,
  parameter int unsigned NCOLS        = 4,
  parameter int unsigned SCAN_DIV     = 16,
  parameter int unsigned DEBOUNCE_CNT = 8,
  parameter int unsigned REPEAT_CYC   = 0,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NROWS-1:0]                  rows,
  output logic [NCOLS-1:0]                  cols,
  output logic                              key_valid,
  output logic [code_w(NROWS, NCOLS)-1:0]   key_code,
  input  logic                              key_ready,
  output logic                              key_held,
  output logic                              overflow
);
  localparam int unsigned CODE_W  = code_w(NROWS, NCOLS);
  localparam int unsigned RW      = $clog2(NROWS);
  localparam int unsigned CW      = $clog2(NCOLS);
  localparam int unsigned DVW     = $clog2(SCAN_DIV);
  localparam int unsigned DBW     = $clog2(DEBOUNCE_CNT + 1);
  localparam int unsigned RPW     = $clog2(REPEAT_CYC + 2);
  localparam int unsigned RepLast = (REPEAT_CYC > 0) ? REPEAT_CYC - 1 : 0;

  if (!params_ok(NROWS, NCOLS, SCAN_DIV, DEBOUNCE_CNT, FIFO_DEPTH)) begin : g_bad_params
    $error("keypad_scanner: illegal parameter set");
  end

  state_e            state_q, state_d;
  logic [CW-1:0]     c_q, c_d, col_next;
  logic [RW-1:0]     r_q, r_d, low_row;
  logic [DVW-1:0]    dwell_q, dwell_d;
  logic [DBW-1:0]    deb_q, deb_d;
  logic [RPW-1:0]    rep_q, rep_d;
  logic [NROWS-1:0]  sync_q, rs_q;
  logic [NCOLS-1:0]  cols_q, cols_d;
  logic              held_q, held_d;
  logic              any_low, row_bit, push, fifo_full, fifo_empty;
  logic [CODE_W-1:0] code;

  assign row_bit  = rs_q[r_q];
  assign col_next = (c_q == CW'(NCOLS - 1)) ? '0 : c_q + 1'b1;
  assign code     = CODE_W'(r_q) * CODE_W'(NCOLS) + CODE_W'(c_q);

  // Lowest-index low row wins when several rows on the driven column are pressed.
  always_comb begin
    any_low = 1'b0;
    low_row = '0;
    for (int i = int'(NROWS) - 1; i >= 0; i--) begin
      if (!rs_q[i]) begin
        any_low = 1'b1;
        low_row = RW'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    r_d     = r_q;
    dwell_d = dwell_q;
    deb_d   = deb_q;
    rep_d   = rep_q;
    push    = 1'b0;
    unique case (state_q)
      StScan: begin
        if (dwell_q == DVW'(SCAN_DIV - 1)) begin
          dwell_d = '0;
          if (any_low) begin
            r_d     = low_row;
            deb_d   = '0;
            state_d = StDebounce;
          end else begin
            c_d = col_next;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      StDebounce: begin
        if (row_bit) begin
          state_d = StScan;
          dwell_d = '0;
        end else if (deb_q == DBW'(DEBOUNCE_CNT - 1)) begin
          push    = 1'b1;
          state_d = StHeld;
          deb_d   = '0;
          rep_d   = '0;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      StHeld: begin
        // deb_q counts consecutive release samples here.
        if (row_bit) begin
          if (deb_q == DBW'(DEBOUNCE_CNT - 1)) begin
            state_d = StScan;
            c_d     = col_next;
            dwell_d = '0;
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end else begin
          deb_d = '0;
          if (REPEAT_CYC > 0) begin
            if (rep_q == RPW'(RepLast)) begin
              push  = 1'b1;
              rep_d = '0;
            end else begin
              rep_d = rep_q + 1'b1;
            end
          end
        end
      end
      default: state_d = StScan;
    endcase
    cols_d = ~(NCOLS'(1) << c_d);
    held_d = (state_d == StHeld);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StScan;
      c_q     <= '0;
      r_q     <= '0;
      dwell_q <= '0;
      deb_q   <= '0;
      rep_q   <= '0;
      sync_q  <= '1;
      rs_q    <= '1;
      cols_q  <= '1;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      r_q     <= r_d;
      dwell_q <= dwell_d;
      deb_q   <= deb_d;
      rep_q   <= rep_d;
      sync_q  <= rows;
      rs_q    <= sync_q;
      cols_q  <= cols_d;
      held_q  <= held_d;
    end
  end

  key_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk),
    .rst_ni     (rst),
    .push_i     (push),
    .din_i      (code),
    .full_o     (fifo_full),
    .pop_i      (key_ready),
    .dout_o     (key_code),
    .empty_o    (fifo_empty),
    .overflow_o (overflow)
  );

  assign cols      = cols_q;
  assign key_held  = held_q;
  assign key_valid = !fifo_empty;

endmodule
